vga_plot_arbiter: RTL



---
 rtl/vga_plot_arbiter_pkg.sv | 25 ++
 rtl/vga_plot_arbiter_clear_scan.sv | 45 ++++
 rtl/vga_plot_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared screen geometry, pixel record and FSM encoding for the VGA plot arbiter.
package vga_plot_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic on_screen(input pixel_t p);
    return (p.x < X_W'(SCREEN_W)) && (p.y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_clear_scan.sv
// Raster counter for the clear sweep: x inner, y outer, returns to (0,0) after the last pixel.
module vga_plot_arbiter_clear_scan
  import vga_plot_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end;

  assign x_end  = (x_q == X_W'(SCREEN_W - 1));
  assign last_o = x_end && (y_q == Y_W'(SCREEN_H - 1));
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = last_o ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter with burst lock sharing the VGA adapter pixel port, plus a preempting clear sweep.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int                  NUM_REQ      = 4,
  parameter int                  MAX_BURST    = 8,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic [X_W-1:0]               plot_x,
  output logic [Y_W-1:0]               plot_y,
  output logic [COLOUR_W-1:0]          plot_colour,
  output logic                         plot,
  output logic [2:0]                   grant_id,
  output logic                         oob
);

  localparam int         IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_e         state_q;
  logic [IW-1:0]  last_grant_q;
  logic [7:0]     burst_cnt_q, burst_cnt_d;
  pixel_t         pix_q;
  logic           plot_q, oob_q, done_q, busy_q;

  pixel_t         req_pix [NUM_REQ];
  pixel_t         gnt_pix, scan_pix;
  logic [IW-1:0]  gnt_idx, cand;
  logic           gnt_vld;
  logic [X_W-1:0] scan_x;
  logic [Y_W-1:0] scan_y;
  logic           scan_last, scan_en;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_pix[i] = '{x:      req_x[i*X_W +: X_W],
                          y:      req_y[i*Y_W +: Y_W],
                          colour: req_colour[i*COLOUR_W +: COLOUR_W]};
  end

  // burst_cnt_q == 0 means nobody transferred last cycle, so nobody owns the port
  // and the search starts fresh after last_grant (gives requester 0 priority out of reset).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    cand    = last_grant_q;
    if (reset_n && state_q == ST_ARB && !clear_start) begin
      if (burst_cnt_q != 8'd0 && burst_cnt_q < MAXB && req_valid[last_grant_q]) begin
        gnt_vld = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
          if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  assign gnt_pix     = req_pix[gnt_idx];
  assign burst_cnt_d = (gnt_idx != last_grant_q) ? 8'd1 :
                       (burst_cnt_q == MAXB)     ? MAXB : burst_cnt_q + 8'd1;
  assign req_ready   = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign grant_id    = gnt_vld ? 3'(gnt_idx) : 3'd0;

  // The first sweep pixel is emitted straight from the start cycle so the sweep
  // occupies exactly one plot per cycle with no bubble.
  assign scan_en  = reset_n && ((state_q == ST_ARB && clear_start) ||
                                (state_q == ST_CLEAR && !done_q));
  assign scan_pix = '{x: scan_x, y: scan_y, colour: CLEAR_COLOUR};

  vga_plot_arbiter_clear_scan u_scan (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (scan_en),
    .x_o    (scan_x),
    .y_o    (scan_y),
    .last_o (scan_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= IW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      pix_q        <= '0;
      plot_q       <= 1'b0;
      oob_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      oob_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (clear_start) begin
            state_q     <= ST_CLEAR;
            busy_q      <= 1'b1;
            plot_q      <= 1'b1;
            pix_q       <= scan_pix;
            burst_cnt_q <= '0;
          end else if (gnt_vld) begin
            last_grant_q <= gnt_idx;
            burst_cnt_q  <= burst_cnt_d;
            if (on_screen(gnt_pix)) begin
              plot_q <= 1'b1;
              pix_q  <= gnt_pix;
            end else begin
              oob_q <= 1'b1;
            end
          end else begin
            burst_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          burst_cnt_q <= '0;
          if (done_q) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b0;
          end else begin
            plot_q <= 1'b1;
            pix_q  <= scan_pix;
            done_q <= scan_last;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign plot        = plot_q;
  assign plot_x      = pix_q.x;
  assign plot_y      = pix_q.y;
  assign plot_colour = pix_q.colour;
  assign oob         = oob_q;
  assign clear_done  = done_q;
  assign clear_busy  = busy_q;

endmodule
